// File: rtl/knn_cache_streamer_pkg.sv
// Shared types for the KNN cache streamer: FSM state encoding and the
// per-word stream tag carried alongside each cache read.
package knn_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic last;
    logic eop;
  } tag_t;

  localparam int TAG_W = 2;

endpackage

// File: rtl/knn_cache_streamer_if.sv
// Cache port-2 Avalon bus plus the outbound word stream of the KNN streamer.
// Stream rule: a word transfers on a clock edge where out_valid & out_ready are
// both high; while out_valid=1 and out_ready=0, out_data/out_last/out_eop hold.
interface knn_cache_streamer_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0] cache_address;
  logic              cache_chipselect;
  logic              cache_clken;
  logic              cache_write;
  logic [3:0]        cache_byteenable;
  logic [DATA_W-1:0] cache_readdata;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              out_eop;

  modport master (
    output cache_address, cache_chipselect, cache_clken, cache_write, cache_byteenable,
    input  cache_readdata,
    output out_data, out_valid, out_last, out_eop,
    input  out_ready
  );

  modport slave (
    input  cache_address, cache_chipselect, cache_clken, cache_write, cache_byteenable,
    output cache_readdata,
    input  out_data, out_valid, out_last, out_eop,
    output out_ready
  );

endinterface

// File: rtl/knn_cache_streamer_fifo.sv
// knn_stream_fifo: small synchronous FIFO with occupancy count and a
// synchronous flush; pointers wrap naturally because DEPTH is a power of 2.
module knn_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 34
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = wr_en & (r_count != FULL_CNT) & ~flush;
  assign w_pop  = rd_en & (r_count != '0) & ~flush;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign empty   = (r_count == '0);
  assign count   = r_count;

endmodule

// File: rtl/knn_cache_streamer.sv
// Reads vec_len*num_vec words from the training cache (port 2) and streams them
// with vector/job delimiters. Optional stall counter: KNN_STREAMER_STALL_CNT_EN.
module knn_cache_streamer
  import knn_acc_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 9,
  parameter int NUM_W      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic [NUM_W-1:0]  num_vec,
  output logic              busy,
  output logic              done,
  output state_t            state_dbg,
  knn_cache_streamer_if.master bus
`ifdef KNN_STREAMER_STALL_CNT_EN
  , output logic [31:0]     stall_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [LEN_W-1:0]  r_word_cnt;
  logic [NUM_W-1:0]  r_vec_cnt;
  logic [LEN_W-1:0]  r_vec_len;
  logic [NUM_W-1:0]  r_num_vec;
  logic              r_inflight;
  tag_t              r_inflight_tag;
  logic              r_done;

  logic [CNT_W-1:0]        w_fifo_count;
  logic                    w_fifo_empty;
  logic [DATA_W+TAG_W-1:0] w_fifo_rd_data;
  logic [DATA_W-1:0]       w_out_data;
  tag_t                    w_out_tag;
  logic [CNT_W:0]          w_outstanding;
  logic                    w_start_ok;
  logic                    w_zero_job;
  logic                    w_issue;
  logic                    w_last_word;
  logic                    w_last_vec;
  tag_t                    w_tag;
  logic                    w_hs;
  logic                    w_eop_hs;

  // A start is refused in the done-pulse cycle so a job never overlaps its own tail.
  assign w_start_ok  = start & ~abort & (r_state == ST_IDLE) & ~r_done;
  assign w_zero_job  = (vec_len == '0) | (num_vec == '0);

  // Credit uses registered occupancy only, so a word read now always has a slot.
  assign w_outstanding = {1'b0, w_fifo_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_issue       = (r_state == ST_RUN) & ~abort &
                         (w_outstanding < (CNT_W+1)'(FIFO_DEPTH));

  assign w_last_word = (r_word_cnt == (r_vec_len - LEN_W'(1)));
  assign w_last_vec  = (r_vec_cnt == (r_num_vec - NUM_W'(1)));
  assign w_tag       = '{last: w_last_word, eop: w_last_word & w_last_vec};

  assign {w_out_data, w_out_tag} = w_fifo_empty ? '0 : w_fifo_rd_data;
  assign w_hs     = ~w_fifo_empty & bus.out_ready;
  assign w_eop_hs = w_hs & w_out_tag.eop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_start_ok && !w_zero_job) w_state_nxt = ST_RUN;
        ST_RUN:   if (w_issue && w_tag.eop)      w_state_nxt = ST_DRAIN;
        ST_DRAIN: if (w_eop_hs)                  w_state_nxt = ST_IDLE;
        default:                                 w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy                 = (r_state != ST_IDLE);
    done                 = r_done;
    state_dbg            = r_state;
    bus.cache_chipselect = w_issue;
    bus.cache_address    = r_rd_addr;
    bus.cache_clken      = 1'b1;
    bus.cache_write      = 1'b0;
    bus.cache_byteenable = 4'hF;
    bus.out_valid        = ~w_fifo_empty;
    bus.out_data         = w_out_data;
    bus.out_last         = w_out_tag.last;
    bus.out_eop          = w_out_tag.eop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_addr      <= '0;
      r_word_cnt     <= '0;
      r_vec_cnt      <= '0;
      r_vec_len      <= '0;
      r_num_vec      <= '0;
      r_inflight     <= 1'b0;
      r_inflight_tag <= '0;
      r_done         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_inflight <= 1'b0;
      end else begin
        r_inflight     <= w_issue;
        r_inflight_tag <= w_tag;
        if (w_start_ok) begin
          r_rd_addr  <= base_addr;
          r_vec_len  <= vec_len;
          r_num_vec  <= num_vec;
          r_word_cnt <= '0;
          r_vec_cnt  <= '0;
          r_done     <= w_zero_job;
        end else if (w_issue) begin
          r_rd_addr <= r_rd_addr + ADDR_W'(1);
          if (w_last_word) begin
            r_word_cnt <= '0;
            r_vec_cnt  <= r_vec_cnt + NUM_W'(1);
          end else begin
            r_word_cnt <= r_word_cnt + LEN_W'(1);
          end
        end
        if ((r_state == ST_DRAIN) && w_eop_hs) r_done <= 1'b1;
      end
    end
  end

  // Read data is only valid the cycle after the address, so capture rides r_inflight.
  knn_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W + TAG_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (abort),
    .wr_en   (r_inflight),
    .wr_data ({bus.cache_readdata, r_inflight_tag}),
    .rd_en   (w_hs),
    .rd_data (w_fifo_rd_data),
    .empty   (w_fifo_empty),
    .count   (w_fifo_count)
  );

`ifdef KNN_STREAMER_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (w_start_ok) begin
      r_stall_cnt <= '0;
    end else if ((r_state != ST_IDLE) && !w_fifo_empty && !bus.out_ready &&
                 (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_knn_cache_streamer.sv
// Bench for knn_cache_streamer: cache model, table of jobs, random jobs and
// hand sequences for abort, reset, ignored starts and (optionally) stall count.
`timescale 1ns/1ps
module tb_knn_cache_streamer;
  import knn_acc_pkg::*;

  localparam int ADDR_W = 9, DATA_W = 32, LEN_W = 9, NUM_W = 10, FIFO_DEPTH = 4;
  typedef logic [DATA_W+1:0] word_t;

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    logic [NUM_W-1:0]  num;
    int                pct;
    int                exp_words;
    int                exp_done;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  vec_len = '0;
  logic [NUM_W-1:0]  num_vec = '0;
  logic              busy, done;
  state_t            state_dbg;
`ifdef KNN_STREAMER_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  knn_cache_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  knn_cache_streamer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .NUM_W(NUM_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .vec_len   (vec_len),
    .num_vec   (num_vec),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg),
    .bus       (bus)
`ifdef KNN_STREAMER_STALL_CNT_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  // clock / cache model
  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [512];
  logic [ADDR_W-1:0] r_cache_addr = '0;
  always @(posedge clk) r_cache_addr <= bus.cache_address;
  assign bus.cache_readdata = mem[r_cache_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard / monitor
  word_t             exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  int n_vec = 0, n_err = 0;
  int hs_cnt, rd_cnt, done_cnt, first_hs_cyc, last_hs_cyc, done_cyc, max_out;
  bit busy_seen, prev_stall;
  word_t prev_word;

  task automatic clear_mon();
    hs_cnt = 0; rd_cnt = 0; done_cnt = 0; first_hs_cyc = 0; last_hs_cyc = 0;
    done_cyc = 0; max_out = 0; busy_seen = 0; prev_stall = 0;
    exp_q.delete(); addr_q.delete();
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  always @(negedge clk) begin
    word_t got, e;
    if (reset_n) begin
      got = {bus.out_data, bus.out_last, bus.out_eop};
      if (busy) busy_seen = 1;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (bus.cache_chipselect) begin rd_cnt++; addr_q.push_back(bus.cache_address); end
      if (prev_stall) begin
        n_vec++;
        if (!bus.out_valid || got !== prev_word) begin
          n_err++;
          $display("FAIL stall_hold: got valid=%0b word=%h required valid=1 word=%h",
                   bus.out_valid, got, prev_word);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_vec++;
        if (hs_cnt == 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL stream_word: got unexpected word %h required none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_err++;
            $display("FAIL stream_word #%0d: got %h required %h", hs_cnt, got, e);
          end
        end
      end
      if (rd_cnt - hs_cnt > max_out) max_out = rd_cnt - hs_cnt;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_word  = got;
    end
  end

  // reference model: word k of the job comes from (base+k) mod 512
  task automatic build_expected(input int b, input int l, input int n);
    word_t w;
    int a;
    for (int k = 0; k < l * n; k++) begin
      a = (b + k) % 512;
      w = {mem[a], 1'b0, 1'b0};
      w[1] = ((k % l) == l - 1);
      w[0] = (k == l * n - 1);
      exp_q.push_back(w);
    end
  endtask

  // driver tasks (called at posedge+1)
  task automatic run_job(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l,
                         input logic [NUM_W-1:0] n, input int pct,
                         input int exp_words, input int exp_done);
    int start_cyc, budget;
    bit ok;
    clear_mon();
    build_expected(int'(b), int'(l), int'(n));
    base_addr = b; vec_len = l; num_vec = n; start = 1'b1;
    start_cyc = cyc;
    bus.out_ready = ($urandom_range(99) < pct);
    @(posedge clk); #1;
    start = 1'b0;
    budget = 20 * (exp_words + 4) + 50;
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      if (done_cnt > 0) begin ok = 1; break; end
      bus.out_ready = ($urandom_range(99) < pct);
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL job_timeout: got no done within %0d cycles required done", budget);
    end
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("words", hs_cnt, exp_words);
    check("reads", rd_cnt, exp_words);
    check("done_pulses", done_cnt, exp_done);
    check("exp_q_left", exp_q.size(), 0);
    check("outstanding_ok", max_out <= FIFO_DEPTH, 1);
    check("busy_seen", busy_seen, exp_words > 0);
    check("busy_end", busy, 0);
    for (int k = 0; k < addr_q.size() && k < exp_words; k++)
      check("cache_address", addr_q[k], (int'(b) + k) % 512);
    if (exp_words == 0) begin
      check("zero_done_cycle", done_cyc, start_cyc + 1);
    end else if (pct == 100) begin
      check("first_word_latency", first_hs_cyc - start_cyc, 3);
      check("contiguous_words", last_hs_cyc - first_hs_cyc, exp_words - 1);
      check("done_after_last", done_cyc, last_hs_cyc + 1);
    end
  endtask

  vec_t tbl[7];
  bit   got_done;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{9'h010, 9'd4,  10'd3, 100, 12, 1};
    tbl[1] = '{9'h1FE, 9'd4,  10'd1, 100, 4,  1};
    tbl[2] = '{9'h005, 9'd0,  10'd3, 100, 0,  1};
    tbl[3] = '{9'h020, 9'd5,  10'd0, 100, 0,  1};
    tbl[4] = '{9'h080, 9'd7,  10'd6, 50,  42, 1};
    tbl[5] = '{9'h1FF, 9'd1,  10'd1, 100, 1,  1};
    tbl[6] = '{9'h1F0, 9'd20, 10'd2, 30,  40, 1};
    for (int i = 0; i < 512; i++) mem[i] = DATA_W'(i);
    bus.out_ready = 1'b1;
    clear_mon();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_chipselect", bus.cache_chipselect, 0);
    check("rst_address", bus.cache_address, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_eop", bus.out_eop, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_clken", bus.cache_clken, 1);
    check("rst_write", bus.cache_write, 0);
    check("rst_byteenable", bus.cache_byteenable, 4'hF);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      run_job(tbl[i].base, tbl[i].len, tbl[i].num, tbl[i].pct, tbl[i].exp_words, tbl[i].exp_done);

    // abort wins over a simultaneous start
    clear_mon();
    base_addr = 9'h030; vec_len = 9'd2; num_vec = 10'd2; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_start_reads", rd_cnt, 0);
    check("abort_start_busy", busy_seen, 0);
    check("abort_start_done", done_cnt, 0);

    // abort after 5 words
    clear_mon();
    build_expected(9'h100, 8, 4);
    base_addr = 9'h100; vec_len = 9'd8; num_vec = 10'd4; start = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 50 && hs_cnt < 5; c++) begin @(posedge clk); #1; end
    check("abort_words_before", hs_cnt, 5);
    abort = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_state", state_dbg, ST_IDLE);
    clear_mon();
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_no_words", hs_cnt, 0);
    check("abort_no_reads", rd_cnt, 0);
    run_job(9'h150, 9'd3, 10'd2, 100, 6, 1);

    // asynchronous reset mid-job
    clear_mon();
    build_expected(9'h000, 6, 3);
    base_addr = 9'h000; vec_len = 9'd6; num_vec = 10'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_chipselect", bus.cache_chipselect, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check("arst_no_done", done_cnt, 0);
    run_job(9'h0A0, 9'd2, 10'd3, 100, 6, 1);

    // starts while busy and in the done-pulse cycle are ignored
    clear_mon();
    build_expected(9'h040, 3, 2);
    base_addr = 9'h040; vec_len = 9'd3; num_vec = 10'd2; start = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    base_addr = 9'h1A0; vec_len = 9'd2; num_vec = 10'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got_done = 0;
    for (int c = 0; c < 100; c++) begin
      if (done) begin got_done = 1; break; end
      @(posedge clk); #1;
    end
    check("busy_job_done_seen", got_done, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("ignored_start_busy", busy, 0);
    check("ignored_start_reads", rd_cnt, 6);
    check("ignored_start_words", hs_cnt, 6);
    check("ignored_start_done", done_cnt, 1);
    check("ignored_start_exp_left", exp_q.size(), 0);

`ifdef KNN_STREAMER_STALL_CNT_EN
    // 10 stalled cycles, plus an ignored start while stalled
    clear_mon();
    build_expected(9'h0C0, 8, 1);
    base_addr = 9'h0C0; vec_len = 9'd8; num_vec = 10'd1; start = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 20 && !bus.out_valid; c++) begin @(posedge clk); #1; end
    check("stall_valid_seen", bus.out_valid, 1);
    for (int c = 0; c < 10; c++) begin
      start = (c == 3);
      if (c == 3) base_addr = 9'h1C0;
      @(posedge clk); #1;
    end
    start = 1'b0; bus.out_ready = 1'b1;
    got_done = 0;
    for (int c = 0; c < 100; c++) begin
      if (done) begin got_done = 1; break; end
      @(posedge clk); #1;
    end
    check("stall_job_done", got_done, 1);
    repeat (4) @(posedge clk);
    #1;
    check("stall_cnt", stall_cnt, 10);
    check("stall_words", hs_cnt, 8);
    check("stall_reads", rd_cnt, 8);
    check("stall_exp_left", exp_q.size(), 0);
`endif

    // randomized jobs over random cache contents
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    for (int j = 0; j < 12; j++) begin
      logic [ADDR_W-1:0] rb;
      logic [LEN_W-1:0]  rl;
      logic [NUM_W-1:0]  rn;
      rb = ADDR_W'($urandom_range(511));
      rl = LEN_W'($urandom_range(6, 1));
      rn = NUM_W'($urandom_range(4, 1));
      run_job(rb, rl, rn, 50, int'(rl) * int'(rn), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/knn_cache_streamer.md
Name: knn_cache_streamer

Overview:
- Read-side neighbour of the 512x32 dual-port training-vector cache. Drives the cache's second Avalon port (address2/chipselect2/clken2/write2) to fetch feature vectors.
- Presents the fetched words as a valid/ready stream to the parallel distance units, with vector and frame delimiters.
- Host (Nios) loads the cache through port 1 and programs a job here.
- Cache port-2 read timing is fixed: address registered on clk, readdata unregistered, so read data is valid exactly 1 cycle after the address is presented.

Parameters:
- ADDR_W, 9, cache word-address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 32, cache/stream data width.
- LEN_W, 9, width of vec_len (words per vector).
- NUM_W, 10, width of num_vec (vectors per job).
- FIFO_DEPTH, 4, output buffer depth; power of 2, >= 2.

Ports:
- clk  in  1  single clock; cache port-2 clock (clk2) is tied to it.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job request; ignored while busy.
- abort  in  1  synchronous job cancel.
- base_addr  in  ADDR_W  first word address; sampled on accepted start.
- vec_len  in  LEN_W  words per vector; sampled on accepted start.
- num_vec  in  NUM_W  vectors in job; sampled on accepted start.
- busy  out  1  high while a job is active.
- done  out  1  one-cycle pulse after the last word handshakes.
- cache_address  out  ADDR_W  to cache address2.
- cache_chipselect  out  1  to chipselect2.
- cache_clken  out  1  to clken2; constant 1.
- cache_write  out  1  to write2; constant 0.
- cache_byteenable  out  4  to byteenable2; constant 4'hF.
- cache_readdata  in  DATA_W  from readdata2.
- out_data  out  DATA_W  stream word.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_last  out  1  qualifies the last word of each vector.
- out_eop  out  1  qualifies the last word of the job.

Behaviour:
- Reset values: busy=0, done=0, cache_chipselect=0, cache_address=0, out_valid=0, out_last=0, out_eop=0, out_data=0. The FIFO is emptied and the in-flight flag cleared.
- FSM states: IDLE, RUN, DRAIN.
- IDLE: start=1 latches the job fields and moves to RUN with busy=1. If vec_len==0 or num_vec==0, the FSM stays in IDLE, issues no reads and pulses done on the next cycle.
- RUN: issue one read per cycle while (fifo_count + inflight) < FIFO_DEPTH, using registered counts only.
  - Issuing a read sets cache_chipselect=1 and cache_address=rd_addr.
  - rd_addr increments by 1 per read and wraps from 2^ADDR_W-1 to 0.
  - A word counter and a vector counter track position. The tag bits (last, eop) travel alongside the inflight flag.
- Captured word: on the cycle after an issued read, cache_readdata and its tags are pushed into the FIFO.
- Moves to DRAIN after the final read is issued.
- DRAIN: no reads. When the final word (eop) handshakes, the FSM goes to IDLE, busy drops and done pulses 1 cycle.
- Latency: start accepted at edge E0 → first read presented in the following cycle → captured at E2 → out_valid=1 after E2.
- Throughput: 1 word/clk sustained while out_ready=1.
- Handshake: transfer when out_valid & out_ready. While out_valid=1 and out_ready=0, out_data, out_last and out_eop are held stable.
- Backpressure: the credit rule guarantees no FIFO overflow and no dropped read data.
- abort (any state): the FIFO is flushed, any in-flight read is discarded and the FSM goes to IDLE. busy=0 next cycle, no done pulse. abort has priority over a simultaneous start.
- A start arriving while busy is ignored, including in the cycle done pulses.
- An asynchronous reset mid-job aborts the job silently.
- Total words in a job = vec_len*num_vec. Counters must be sized so the 511x1023 job completes; the address simply wraps.

Optional Feature:
- Macro: KNN_STREAMER_STALL_CNT_EN.
- With the macro defined:
  - Adds output stall_cnt[31:0], which counts cycles with out_valid=1 and out_ready=0 during a job.
  - The counter clears on accepted start and on reset, saturates at all-ones, and holds its value after done.
- Without the macro: the port and logic are absent.

Decomposition:
- Package knn_acc_pkg: the state enum (IDLE/RUN/DRAIN) and the stream tag struct {last, eop}.
- Sub-module: knn_stream_fifo, a synchronous FIFO (FIFO_DEPTH x DATA_W+2) with count output. Its write is gated by the inflight-capture strobe and its read by the handshake.

Test Plan:
- Basic job: base=0x010, vec_len=4, num_vec=3, cache[i]=i, out_ready=1 → 12 words 0x10..0x1B on consecutive cycles; first word follows the latency above; out_last on words 4, 8 and 12; out_eop on word 12; done pulse 1 cycle later.
- Wrap-around: base=0x1FE, vec_len=4, num_vec=1 → cache_address sequence 0x1FE, 0x1FF, 0x000, 0x001; data matches in order.
- Backpressure: random 50% out_ready → no loss or duplication; outstanding reads never exceed FIFO_DEPTH; outputs stable while stalled.
- Zero length: vec_len=0 → no cache_chipselect, done pulse, busy never set.
- Abort mid-job: abort after 5 words → busy=0 next cycle, no done; FIFO empty; a following job outputs only its own data.
- Start while busy plus stall counter (macro on): out_ready=0 for 10 cycles → stall_cnt=10; the extra start is ignored.
